// File: rtl/clock_set_ctrl.sv
// Button-driven time-setting controller: snapshots the running time, lets the user
// edit hour/minute/second in turn, then strobes the counter's time-load port.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 30,
    parameter int unsigned COMMIT_CYCLES  = 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       mode_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       cancel_i,
    input  logic [4:0] hour_i,
    input  logic [5:0] min_i,
    input  logic [5:0] sec_i,
    output logic       timeset_o,
    output logic [4:0] hourset_o,
    output logic [5:0] minset_o,
    output logic [5:0] secset_o,
    output logic       editing_o,
    output logic [1:0] field_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CW = (COMMIT_CYCLES > 1) ? $clog2(COMMIT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CMT_LAST = CW'(COMMIT_CYCLES - 1);

    typedef enum logic [2:0] {
        RUN,
        EDIT_H,
        EDIT_M,
        EDIT_S,
        COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [CW-1:0] cmt_q, cmt_d;
    logic [4:0]    hour_d;
    logic [5:0]    min_d, sec_d;
    logic          up, down;
    logic          editing_d;
    logic [1:0]    field_d;

    function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] max_v,
                                              input logic inc, input logic dec);
        logic [5:0] r;
        r = v;
        if (inc) r = (v == max_v) ? 6'd0 : v + 6'd1;
        else if (dec) r = (v == 6'd0) ? max_v : v - 6'd1;
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        cmt_d   = cmt_q;
        hour_d  = hourset_o;
        min_d   = minset_o;
        sec_d   = secset_o;
        // simultaneous inc and dec cancel out but still count as activity
        up      = inc_i & ~dec_i;
        down    = dec_i & ~inc_i;

        case (state_q)
            RUN: begin
                if (mode_i) begin
                    hour_d  = hour_i;
                    min_d   = min_i;
                    sec_d   = sec_i;
                    tmo_d   = '0;
                    state_d = EDIT_H;
                end
            end
            EDIT_H, EDIT_M, EDIT_S: begin
                if (cancel_i) begin
                    state_d = RUN;
                end else if (mode_i) begin
                    tmo_d = '0;
                    case (state_q)
                        EDIT_H:  state_d = EDIT_M;
                        EDIT_M:  state_d = EDIT_S;
                        default: begin
                            state_d = COMMIT;
                            cmt_d   = '0;
                        end
                    endcase
                end else if (inc_i || dec_i) begin
                    tmo_d = '0;
                    case (state_q)
                        EDIT_H:  hour_d = 5'(step_field({1'b0, hourset_o}, 6'd23, up, down));
                        EDIT_M:  min_d  = step_field(minset_o, 6'd59, up, down);
                        default: sec_d  = step_field(secset_o, 6'd59, up, down);
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = RUN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            COMMIT: begin
                if (cmt_q == CMT_LAST) state_d = RUN;
                else cmt_d = cmt_q + 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        editing_d = 1'b0;
        field_d   = 2'd0;
        case (state_d)
            EDIT_H: begin editing_d = 1'b1; field_d = 2'd1; end
            EDIT_M: begin editing_d = 1'b1; field_d = 2'd2; end
            EDIT_S: begin editing_d = 1'b1; field_d = 2'd3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= RUN;
            tmo_q     <= '0;
            cmt_q     <= '0;
            hourset_o <= '0;
            minset_o  <= '0;
            secset_o  <= '0;
            timeset_o <= 1'b0;
            editing_o <= 1'b0;
            field_o   <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            cmt_q     <= cmt_d;
            hourset_o <= hour_d;
            minset_o  <= min_d;
            secset_o  <= sec_d;
            timeset_o <= (state_d == COMMIT);
            editing_o <= editing_d;
            field_o   <= field_d;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed vector table plus hand-written
// sequences for timeout and reset-during-commit.
module tb_clock_set_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i, mode_i, inc_i, dec_i, cancel_i;
    logic [4:0] hour_i;
    logic [5:0] min_i, sec_i;
    logic       timeset_o, editing_o;
    logic [4:0] hourset_o;
    logic [5:0] minset_o, secset_o;
    logic [1:0] field_o;

    int total = 0;
    int bad   = 0;

    clock_set_ctrl #(.TIMEOUT_CYCLES(30), .COMMIT_CYCLES(2)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .mode_i    (mode_i),
        .inc_i     (inc_i),
        .dec_i     (dec_i),
        .cancel_i  (cancel_i),
        .hour_i    (hour_i),
        .min_i     (min_i),
        .sec_i     (sec_i),
        .timeset_o (timeset_o),
        .hourset_o (hourset_o),
        .minset_o  (minset_o),
        .secset_o  (secset_o),
        .editing_o (editing_o),
        .field_o   (field_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       mode, inc, dec, cancel;
        logic [4:0] h;
        logic [5:0] m, s;
        logic       ts;
        logic [4:0] eh;
        logic [5:0] em, es;
        logic       ed;
        logic [1:0] ef;
    } vec_t;

    vec_t vecs[$];
    int   t_h, t_m, t_s;

    task automatic add(input int mode, input int inc, input int dec, input int cancel,
                       input int ts, input int eh, input int em, input int es,
                       input int ed, input int ef);
        vec_t v;
        v.mode = 1'(mode); v.inc = 1'(inc); v.dec = 1'(dec); v.cancel = 1'(cancel);
        v.h = 5'(t_h); v.m = 6'(t_m); v.s = 6'(t_s);
        v.ts = 1'(ts); v.eh = 5'(eh); v.em = 6'(em); v.es = 6'(es);
        v.ed = 1'(ed); v.ef = 2'(ef);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int ts, input int eh, input int em,
                             input int es, input int ed, input int ef);
        check({name, ".timeset"}, 32'(timeset_o), 32'(ts));
        check({name, ".hour"},    32'(hourset_o), 32'(eh));
        check({name, ".min"},     32'(minset_o),  32'(em));
        check({name, ".sec"},     32'(secset_o),  32'(es));
        check({name, ".editing"}, 32'(editing_o), 32'(ed));
        check({name, ".field"},   32'(field_o),   32'(ef));
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int mode, input int inc, input int dec, input int cancel);
        mode_i = 1'(mode); inc_i = 1'(inc); dec_i = 1'(dec); cancel_i = 1'(cancel);
    endtask

    initial begin
        reset_i = 1'b1;
        drive(0, 0, 0, 0);
        hour_i = 5'd12; min_i = 6'd34; sec_i = 6'd56;

        // ---- vector table ----
        t_h = 12; t_m = 34; t_s = 56;
        repeat (3) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 12, 34, 56, 1, 1);
        for (int k = 1; k <= 12; k++) add(0, 1, 0, 0, 0, (12 + k) % 24, 34, 56, 1, 1);
        add(1, 0, 0, 0, 0, 0, 34, 56, 1, 2);
        for (int k = 1; k <= 35; k++) add(0, 0, 1, 0, 0, 0, (94 - k) % 60, 56, 1, 2);
        add(0, 1, 1, 0, 0, 0, 59, 56, 1, 2);
        add(1, 1, 0, 0, 0, 0, 59, 56, 1, 3);
        add(0, 1, 0, 0, 0, 0, 59, 57, 1, 3);
        add(0, 1, 0, 0, 0, 0, 59, 58, 1, 3);
        add(0, 1, 0, 0, 0, 0, 59, 59, 1, 3);
        add(0, 0, 1, 0, 0, 0, 59, 58, 1, 3);
        add(0, 1, 0, 0, 0, 0, 59, 59, 1, 3);
        add(0, 1, 0, 0, 0, 0, 59, 0, 1, 3);
        add(0, 0, 1, 0, 0, 0, 59, 59, 1, 3);
        add(0, 0, 0, 1, 0, 0, 59, 59, 0, 0);
        add(0, 1, 0, 0, 0, 0, 59, 59, 0, 0);
        add(0, 0, 1, 1, 0, 0, 59, 59, 0, 0);
        t_h = 23; t_m = 59; t_s = 59;
        add(1, 0, 0, 0, 0, 23, 59, 59, 1, 1);
        add(0, 0, 1, 0, 0, 22, 59, 59, 1, 1);
        add(0, 1, 0, 0, 0, 23, 59, 59, 1, 1);
        add(0, 1, 0, 0, 0, 0, 59, 59, 1, 1);
        add(0, 0, 1, 0, 0, 23, 59, 59, 1, 1);
        add(1, 0, 0, 0, 0, 23, 59, 59, 1, 2);
        add(1, 0, 0, 0, 0, 23, 59, 59, 1, 3);
        add(1, 0, 0, 0, 1, 23, 59, 59, 0, 0);
        add(0, 1, 0, 1, 1, 23, 59, 59, 0, 0);
        add(0, 0, 0, 0, 0, 23, 59, 59, 0, 0);
        add(0, 0, 0, 0, 0, 23, 59, 59, 0, 0);
        t_h = 1; t_m = 2; t_s = 3;
        add(1, 0, 0, 0, 0, 1, 2, 3, 1, 1);
        add(1, 0, 0, 0, 0, 1, 2, 3, 1, 2);
        add(1, 0, 0, 1, 0, 1, 2, 3, 0, 0);
        add(0, 0, 0, 0, 0, 1, 2, 3, 0, 0);

        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0, 0);
        reset_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].mode, vecs[i].inc, vecs[i].dec, vecs[i].cancel);
            hour_i = vecs[i].h; min_i = vecs[i].m; sec_i = vecs[i].s;
            tick();
            check_all($sformatf("v%0d", i), vecs[i].ts, vecs[i].eh, vecs[i].em,
                      vecs[i].es, vecs[i].ed, vecs[i].ef);
        end
        drive(0, 0, 0, 0);

        // ---- timeout with no input: abandoned after 30 idle cycles ----
        hour_i = 5'd5; min_i = 6'd6; sec_i = 6'd7;
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        check_all("to_enter", 0, 5, 6, 7, 1, 1);
        for (int i = 1; i <= 29; i++) begin
            tick();
            check($sformatf("to_idle%0d.editing", i), 32'(editing_o), 32'd1);
            check($sformatf("to_idle%0d.timeset", i), 32'(timeset_o), 32'd0);
        end
        tick();
        check_all("to_expired", 0, 5, 6, 7, 0, 0);
        tick();
        check_all("to_after", 0, 5, 6, 7, 0, 0);

        // ---- timeout restarted by inc at cycle 29 ----
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 28; i++) tick();
        check("to2_c28.editing", 32'(editing_o), 32'd1);
        drive(0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        check_all("to2_inc", 0, 6, 6, 7, 1, 1);
        tick();
        tick();
        check_all("to2_c31", 0, 6, 6, 7, 1, 1);
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        check_all("to2_cancel", 0, 6, 6, 7, 0, 0);

        // ---- reset during first commit cycle ----
        hour_i = 5'd9; min_i = 6'd8; sec_i = 6'd7;
        drive(1, 0, 0, 0);
        repeat (4) tick();
        drive(0, 0, 0, 0);
        check_all("rc_commit", 1, 9, 8, 7, 0, 0);
        reset_i = 1'b1;
        tick();
        check_all("rc_reset", 0, 0, 0, 0, 0, 0);
        reset_i = 1'b0;
        tick();
        check_all("rc_after", 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
